// File: rtl/image_spike_encoder_if.sv
// Spike event port between the image encoder (master) and the SNN core (slave).
// One event per accepted SPK_VALID && SPK_READY beat; SPK_TICK marks end of a timestep.
interface image_spike_encoder_if #(
   parameter int M = 8
);
   logic         SPK_VALID;
   logic         SPK_READY;
   logic [M-1:0] SPK_ADDR;
   logic         SPK_TICK;

   modport master (output SPK_VALID, SPK_ADDR, SPK_TICK, input SPK_READY);
   modport slave  (input SPK_VALID, SPK_ADDR, SPK_TICK, output SPK_READY);
endinterface

// File: rtl/image_spike_encoder.sv
// Rate-codes an image into spike events with per-pixel integrate-and-fire accumulators.
// Optional ENCODER_DITHER_EN seeds each pixel's step-0 accumulator from a 16-bit LFSR.
module image_spike_encoder #(
   parameter int N          = 256,
   parameter int M          = 8,
   parameter int IMAGE_SIZE = 256,
   parameter int PIXEL_BITS = 8,
   parameter int NUM_STEPS  = 16,
   parameter int STEP_BITS  = $clog2(NUM_STEPS + 1)
) (
   input  logic                                 ACLK,
   input  logic                                 ARESETN,
   input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
   input  logic                                 NEW_IMAGE,
   image_spike_encoder_if.master                spk,
   output logic                                 BUSY,
   output logic                                 DONE,
   output logic [STEP_BITS-1:0]                 STEP
);

   // The scan never walks past the input layer, even if IMAGE_SIZE is misconfigured.
   localparam int LAST_PIX = ((IMAGE_SIZE <= N) ? IMAGE_SIZE : N) - 1;

   typedef enum logic [1:0] {IDLE, SCAN, TICK, FIN} state_t;

   state_t                state;
   logic [M-1:0]          pix;
   logic                  pending;
   logic                  new_image_q;
   logic [PIXEL_BITS-1:0] acc [IMAGE_SIZE];

   logic                  spk_valid_q;
   logic                  spk_tick_q;
   logic [M-1:0]          spk_addr_q;

   logic [PIXEL_BITS-1:0] init_val;
   logic [PIXEL_BITS-1:0] acc_old;
   logic [PIXEL_BITS:0]   sum;
   logic                  scan_adv;
   logic                  fire;
   logic                  new_edge;
   logic                  last_pix;
   logic                  last_step;

   assign new_edge  = NEW_IMAGE && !new_image_q;
   assign scan_adv  = (state == SCAN) && (!spk_valid_q || spk.SPK_READY);
   assign acc_old   = (STEP == '0) ? init_val : acc[pix];
   assign sum       = {1'b0, acc_old} + {1'b0, IMAGE[pix]};
   assign fire      = sum[PIXEL_BITS];
   assign last_pix  = (pix == M'(LAST_PIX));
   assign last_step = (STEP == STEP_BITS'(NUM_STEPS - 1));

   assign spk.SPK_VALID = spk_valid_q;
   assign spk.SPK_ADDR  = spk_addr_q;
   assign spk.SPK_TICK  = spk_tick_q;

`ifdef ENCODER_DITHER_EN
   logic [15:0] lfsr;

   // Fibonacci taps 16,14,13,11; shifts once per scanned pixel and is never reseeded per image.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)      lfsr <= 16'hACE1;
      else if (scan_adv) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign init_val = lfsr[PIXEL_BITS-1:0];
`else
   assign init_val = '0;
`endif

   // NOTE: the accumulator array is explicitly cleared on reset so an aborted image leaves no residue.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < IMAGE_SIZE; i++) acc[i] <= '0;
      end else if (scan_adv) begin
         acc[pix] <= sum[PIXEL_BITS-1:0];
      end
   end

   // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state       <= IDLE;
         pix         <= '0;
         pending     <= 1'b0;
         new_image_q <= 1'b0;
         spk_valid_q <= 1'b0;
         spk_tick_q  <= 1'b0;
         spk_addr_q  <= '0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         STEP        <= '0;
      end else begin
         new_image_q <= NEW_IMAGE;
         DONE        <= 1'b0;

         case (state)
            IDLE, FIN: begin
               if (pending) begin
                  pending <= 1'b0;
                  pix     <= '0;
                  STEP    <= '0;
                  BUSY    <= 1'b1;
                  state   <= SCAN;
               end else begin
                  state   <= IDLE;
               end
            end

            SCAN: begin
               if (scan_adv) begin
                  spk_valid_q <= fire;
                  if (fire) begin
                     spk_addr_q <= pix;
                     spk_tick_q <= 1'b0;
                  end
                  if (last_pix) state <= TICK;
                  else          pix   <= pix + 1'b1;
               end
            end

            TICK: begin
               // The marker goes out only once the last pixel event of the step has drained.
               if (!spk_valid_q || (!spk_tick_q && spk.SPK_READY)) begin
                  spk_valid_q <= 1'b1;
                  spk_tick_q  <= 1'b1;
                  spk_addr_q  <= '0;
               end else if (spk_tick_q && spk.SPK_READY) begin
                  spk_valid_q <= 1'b0;
                  spk_tick_q  <= 1'b0;
                  if (last_step) begin
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                     state <= FIN;
                  end else begin
                     STEP  <= STEP + 1'b1;
                     pix   <= '0;
                     state <= SCAN;
                  end
               end
            end

            default: state <= IDLE;
         endcase

         // A fresh request wins over the clear above; repeated edges collapse into one.
         if (new_edge) pending <= 1'b1;
      end
   end

endmodule

// File: doc/image_spike_encoder.md
Name: image_spike_encoder

Overview:
- Sits directly downstream of the AXI4-Lite slave interface and consumes its IMAGE array and NEW_IMAGE flag.
- Converts pixel intensities into rate-coded spike events over NUM_STEPS timesteps using a per-pixel integrate-and-fire accumulator.
- Emits events one at a time on a valid/ready port that feeds the SNN core, with a timestep marker event after each full scan of the image.

Parameters:
- N, 256, maximum number of neurons (input layer size).
- M, 8, log2(N); width of a spike address.
- IMAGE_SIZE, 256, number of pixels; must be <= N.
- PIXEL_BITS, 8, width of one pixel value.
- NUM_STEPS, 16, number of encoding timesteps per image; must be >= 1.
- STEP_BITS, $clog2(NUM_STEPS+1), width of the step counter.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- IMAGE  in  [PIXEL_BITS-1:0] x IMAGE_SIZE  pixel array from the AXI interface, sampled live.
- NEW_IMAGE  in  1  level flag from the AXI interface; its rising edge requests encoding.
- SPK_VALID  out  1  event valid.
- SPK_READY  in  1  event accepted by the SNN core.
- SPK_ADDR  out  M  pixel/neuron index of the event; 0 for tick events.
- SPK_TICK  out  1  1 = timestep-marker event, 0 = pixel spike.
- BUSY  out  1  encoding in progress.
- DONE  out  1  one-cycle pulse when an image has been fully encoded.
- STEP  out  STEP_BITS  index of the current timestep.

Behaviour:
- Reset (async, ARESETN=0): FSM=IDLE; SPK_VALID=0, SPK_ADDR=0, SPK_TICK=0, BUSY=0, DONE=0, STEP=0; pending flag=0; all accumulators=0; NEW_IMAGE edge register=0. Asserting reset mid-operation aborts immediately; any event in flight is dropped.
- Edge detect: when NEW_IMAGE=1 and the registered previous value is 0, set the pending flag.
  - In IDLE or DONE, pending is consumed on the next cycle.
  - While BUSY, pending is held and consumed after the current image finishes. It is not stacked: multiple edges collapse to one request.
- FSM states IDLE, SCAN, TICK, FIN.
  - IDLE/FIN with pending set: clear pending, set pix=0, STEP=0, BUSY=1, go to SCAN.
  - SCAN, per advancing cycle at pixel pix:
    - Compute sum = acc_old + IMAGE[pix] at PIXEL_BITS+1 bits, with no overflow possible.
    - acc_old = init value when STEP==0, otherwise acc[pix].
    - If sum >= 2^PIXEL_BITS: fire. acc[pix] = sum - 2^PIXEL_BITS; next cycle SPK_VALID=1, SPK_ADDR=pix, SPK_TICK=0.
    - Otherwise acc[pix] = sum and no event is issued.
  - Advance rule: SCAN advances only when no event is outstanding or the outstanding event is accepted this cycle (!SPK_VALID || SPK_READY). This gives at most one pixel per cycle, with back-to-back events accepted at full rate.
  - After pix = IMAGE_SIZE-1 advances, go to TICK.
  - TICK: present SPK_VALID=1, SPK_TICK=1, SPK_ADDR=0, once any prior pixel event has been accepted. On acceptance:
    - If STEP == NUM_STEPS-1, go to FIN.
    - Otherwise STEP+1, pix=0, go to SCAN.
  - FIN: BUSY=0 and a one-cycle DONE pulse. Then go to IDLE, or to SCAN directly if pending is set.
- Handshake rules:
  - SPK_ADDR and SPK_TICK are stable while SPK_VALID && !SPK_READY.
  - SPK_VALID never drops without acceptance, except at reset.
  - SPK_VALID is deasserted the cycle after acceptance unless a new event is produced.
- Event count per pixel over the image is floor((init + NUM_STEPS*p) / 2^PIXEL_BITS), where init is 0 by default.
- Latency: with SPK_READY held at 1 and no spikes, one step takes IMAGE_SIZE+1 cycles plus one cycle of tick acceptance.
- IMAGE is sampled live. Upstream holds it stable while BUSY; if it changes, later pixels use the new values and this is not flagged.

Optional Feature:
- Macro ENCODER_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset; never all-zero) supplies the init value as lfsr[PIXEL_BITS-1:0].
  - The LFSR advances once per SCAN advance, in every step, and is not reseeded per image. This decorrelates spike phases between pixels.
- Undefined: the init value is 0 and there is no LFSR logic. Event counts are exactly deterministic.

Test Plan:
- All pixels 0, NEW_IMAGE edge, SPK_READY=1 -> exactly 16 tick events, no pixel events. DONE pulses once; BUSY=1 for 16*(IMAGE_SIZE+2) ± 2 cycles.
- IMAGE[3]=128, IMAGE[7]=255, all others 0 -> 8 events with ADDR=3 (on odd steps 1,3,..,15) and 15 events with ADDR=7 (none in step 0). Ticks are interleaved after each step.
- Same image with SPK_READY toggled randomly -> identical event sequence. ADDR/TICK are stable during every stall and no event is lost or duplicated.
- Second NEW_IMAGE edge (toggle 1→0→1) mid-encode -> the current image completes, then encoding restarts with no IDLE gap. A total of 2 DONE pulses.
- Assert ARESETN=0 during step 5 with SPK_VALID=1 -> all outputs 0 immediately. After release, a new edge encodes from STEP=0 with zeroed accumulators.
- ENCODER_DITHER_EN defined, all pixels 255 -> each pixel fires 15 or 16 times. Step-0 spikes occur at differing pixels, and the total matches the reference model using the LFSR.
